// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - EXEC-side bundle between the pipeline and the branch resolve unit
interface branch_resolve_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              instr_valid;
    logic              stall;
    logic [31:0]       instr_word;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       rs_val;
    logic [31:0]       rt_val;
    logic              clr_cnt;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic              annul;
    logic              link_we;
    logic [4:0]        link_reg;
    logic [ADDR_W-1:0] link_value;
    logic              ds_fault;
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  taken_cnt;

    modport master (
        output instr_valid, stall, instr_word, pc, rs_val, rt_val, clr_cnt,
        input  redirect, redirect_target, annul, link_we, link_reg, link_value,
               ds_fault, branch_cnt, taken_cnt
    );

    modport slave (
        input  instr_valid, stall, instr_word, pc, rs_val, rt_val, clr_cnt,
        output redirect, redirect_target, annul, link_we, link_reg, link_value,
               ds_fault, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - MIPS-I jump/branch resolution with delay-slot sequencing and statistics
module branch_resolve_unit #(
    parameter int ADDR_W      = 32,
    parameter int DELAY_SLOTS = 1,
    parameter int LIKELY_EN   = 0,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    branch_resolve_unit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_PEND, S_ANNUL, S_REDIR} state_t;

    state_t            r_state;
    logic [1:0]        r_left;
    logic              r_redirect;
    logic              r_annul;
    logic              r_ds_fault;
    logic [ADDR_W-1:0] r_target;
    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_taken_cnt;

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [4:0]        w_rt_f;
    logic [25:0]       w_index;
    logic [31:0]       w_boff;
    logic [ADDR_W-1:0] w_pc4;
    logic [31:0]       w_jfull;
    logic              w_eq, w_neg, w_zero, w_cond;
    logic              w_is_jump, w_is_jr, w_is_jalr, w_is_bcmp, w_is_bl, w_is_regimm;
    logic              w_is_ctrl, w_taken, w_links, w_accept, w_eval;
    logic [ADDR_W-1:0] w_target;

    assign w_op    = bus.instr_word[31:26];
    assign w_funct = bus.instr_word[5:0];
    assign w_rt_f  = bus.instr_word[20:16];
    assign w_index = bus.instr_word[25:0];
    assign w_boff  = {{14{bus.instr_word[15]}}, bus.instr_word[15:0], 2'b00};
    assign w_pc4   = bus.pc + ADDR_W'(4);
    // Jump region comes from the incremented PC; narrow ADDR_W simply drops the region bits.
    assign w_jfull = (32'(w_pc4) & 32'hF000_0000) | {4'b0000, w_index, 2'b00};

    assign w_eq   = (bus.rs_val == bus.rt_val);
    assign w_neg  = bus.rs_val[31];
    assign w_zero = (bus.rs_val == 32'd0);

    // Likely opcodes 0101xx mirror 0001xx, so op[1:0] picks the condition for both.
    always_comb begin
        w_cond = 1'b0;
        case (w_op[1:0])
            2'd0:    w_cond = w_eq;
            2'd1:    w_cond = !w_eq;
            2'd2:    w_cond = w_neg || w_zero;
            default: w_cond = !w_neg && !w_zero;
        endcase
    end

    assign w_is_jump   = (w_op[5:1] == 5'b00001);
    assign w_is_jr     = (w_op == 6'd0) && (w_funct == 6'b001000);
    assign w_is_jalr   = (w_op == 6'd0) && (w_funct == 6'b001001);
    assign w_is_bcmp   = (w_op[5:2] == 4'b0001);
    assign w_is_bl     = (LIKELY_EN != 0) && (w_op[5:2] == 4'b0101);
    assign w_is_regimm = (w_op == 6'b000001) && (w_rt_f[3:1] == 3'b000);

    assign w_is_ctrl = w_is_jump || w_is_jr || w_is_jalr || w_is_bcmp || w_is_bl || w_is_regimm;
    assign w_taken   = w_is_jump || w_is_jr || w_is_jalr
                     || ((w_is_bcmp || w_is_bl) && w_cond)
                     || (w_is_regimm && (w_rt_f[0] ? !w_neg : w_neg));
    assign w_links   = (w_op == 6'b000011) || w_is_jalr || (w_is_regimm && w_rt_f[4]);

    always_comb begin
        w_target = w_pc4 + ADDR_W'(w_boff);
        if (w_is_jump)
            w_target = ADDR_W'(w_jfull);
        else if (w_is_jr || w_is_jalr)
            w_target = bus.rs_val[ADDR_W-1:0];
    end

    assign w_accept = bus.instr_valid && !bus.stall;
    assign w_eval   = w_accept && (r_state == S_IDLE) && w_is_ctrl;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_left     <= 2'd0;
            r_redirect <= 1'b0;
            r_annul    <= 1'b0;
            r_ds_fault <= 1'b0;
            r_target   <= '0;
        end else begin
            r_redirect <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_eval && w_taken) begin
                        r_target <= w_target;
                        if (DELAY_SLOTS == 0) begin
                            r_state    <= S_REDIR;
                            r_redirect <= 1'b1;
                        end else begin
                            r_state <= S_PEND;
                            r_left  <= 2'(DELAY_SLOTS);
                        end
                    end else if (w_eval && w_is_bl && DELAY_SLOTS > 0) begin
                        r_state <= S_ANNUL;
                        r_annul <= 1'b1;
                        r_left  <= 2'(DELAY_SLOTS);
                    end
                end
                S_PEND: begin
                    if (w_accept) begin
                        if (w_is_ctrl)
                            r_ds_fault <= 1'b1;
                        if (r_left == 2'd1) begin
                            r_state    <= S_REDIR;
                            r_redirect <= 1'b1;
                        end else begin
                            r_left <= r_left - 2'd1;
                        end
                    end
                end
                S_ANNUL: begin
                    if (w_accept) begin
                        if (r_left == 2'd1) begin
                            r_state <= S_IDLE;
                            r_annul <= 1'b0;
                        end else begin
                            r_left <= r_left - 2'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || bus.clr_cnt) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else if (w_eval) begin
            if (r_branch_cnt != '1)
                r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_taken && r_taken_cnt != '1)
                r_taken_cnt <= r_taken_cnt + 1'b1;
        end
    end

    assign bus.redirect        = r_redirect;
    assign bus.redirect_target = r_target;
    assign bus.annul           = r_annul;
    assign bus.ds_fault        = r_ds_fault;
    assign bus.branch_cnt      = r_branch_cnt;
    assign bus.taken_cnt       = r_taken_cnt;
    assign bus.link_we         = reset_n && w_accept && (r_state == S_IDLE) && w_links;
    assign bus.link_reg        = w_is_jalr ? bus.instr_word[15:11] : 5'd31;
    assign bus.link_value      = bus.pc + ADDR_W'(4 * (DELAY_SLOTS + 1));
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard bench: directed branch vectors on two unit configurations
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic reset_a = 1'b0;
    logic reset_b = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        int          cyc;
        logic [31:0] val;
        logic [4:0]  rg;
    } exp_t;

    exp_t rq_a[$];
    exp_t lq_a[$];
    exp_t rq_b[$];
    exp_t lq_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    branch_resolve_unit_if #(.ADDR_W(32), .CNT_W(16)) bus_a();
    branch_resolve_unit_if #(.ADDR_W(32), .CNT_W(2))  bus_b();

    branch_resolve_unit #(.ADDR_W(32), .DELAY_SLOTS(1), .LIKELY_EN(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_a), .bus(bus_a.slave)
    );
    branch_resolve_unit #(.ADDR_W(32), .DELAY_SLOTS(2), .LIKELY_EN(0), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_b), .bus(bus_b.slave)
    );

    function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
        return {op, 5'd3, rt, imm};
    endfunction
    function automatic logic [31:0] f_j(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction
    function automatic logic [31:0] f_r(input logic [4:0] rd, input logic [5:0] funct);
        return {6'd0, 5'd9, 5'd0, rd, 5'd0, funct};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drv_a(input logic v, input logic s, input logic [31:0] w,
                         input logic [31:0] p, input logic [31:0] rs, input logic [31:0] rt);
        @(posedge clk); #1;
        bus_a.instr_valid = v; bus_a.stall = s; bus_a.instr_word = w;
        bus_a.pc = p; bus_a.rs_val = rs; bus_a.rt_val = rt;
    endtask

    task automatic drv_b(input logic v, input logic s, input logic [31:0] w,
                         input logic [31:0] p, input logic [31:0] rs, input logic [31:0] rt);
        @(posedge clk); #1;
        bus_b.instr_valid = v; bus_b.stall = s; bus_b.instr_word = w;
        bus_b.pc = p; bus_b.rs_val = rs; bus_b.rt_val = rt;
    endtask

    task automatic push(inout exp_t q[$], input int c, input logic [31:0] v, input logic [4:0] r);
        exp_t e;
        e.cyc = c; e.val = v; e.rg = r;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus_a.redirect) begin
            if (rq_a.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL redirect_a unexpected: got target 0x%08h, expected no redirect", bus_a.redirect_target);
            end else begin
                e = rq_a.pop_front();
                chk("redirect_a target", bus_a.redirect_target, e.val);
                chk("redirect_a cycle", cyc, e.cyc);
            end
        end
        if (bus_a.link_we) begin
            if (lq_a.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL link_a unexpected: got link_value 0x%08h, expected no link", bus_a.link_value);
            end else begin
                e = lq_a.pop_front();
                chk("link_a value", bus_a.link_value, e.val);
                chk("link_a reg", 32'(bus_a.link_reg), 32'(e.rg));
                chk("link_a cycle", cyc, e.cyc);
            end
        end
        if (bus_b.redirect) begin
            if (rq_b.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL redirect_b unexpected: got target 0x%08h, expected no redirect", bus_b.redirect_target);
            end else begin
                e = rq_b.pop_front();
                chk("redirect_b target", bus_b.redirect_target, e.val);
                chk("redirect_b cycle", cyc, e.cyc);
            end
        end
        if (bus_b.link_we) begin
            if (lq_b.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL link_b unexpected: got link_value 0x%08h, expected no link", bus_b.link_value);
            end else begin
                e = lq_b.pop_front();
                chk("link_b value", bus_b.link_value, e.val);
                chk("link_b reg", 32'(bus_b.link_reg), 32'(e.rg));
                chk("link_b cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] nop = 32'd0;
        bus_a.clr_cnt = 1'b0; bus_b.clr_cnt = 1'b0;
        bus_a.instr_valid = 1'b1; bus_a.stall = 1'b0; bus_a.instr_word = f_j(6'b000011, 26'h10);
        bus_a.pc = 32'h0; bus_a.rs_val = 0; bus_a.rt_val = 0;
        bus_b.instr_valid = 1'b0; bus_b.stall = 1'b0; bus_b.instr_word = nop;
        bus_b.pc = 32'h0; bus_b.rs_val = 0; bus_b.rt_val = 0;

        // ---------------- unit A: one delay slot, likely branches ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("a reset link_we", 32'(bus_a.link_we), 0);
        chk("a reset redirect", 32'(bus_a.redirect), 0);
        chk("a reset annul", 32'(bus_a.annul), 0);
        chk("a reset branch_cnt", 32'(bus_a.branch_cnt), 0);
        drv_a(0, 0, nop, 0, 0, 0); reset_a = 1'b1;

        drv_a(1, 0, f_i(6'b000100, 5'd4, 16'h0003), 32'h100, 5, 5);
        drv_a(1, 0, nop, 32'h104, 0, 0); push(rq_a, cyc + 1, 32'h110, 0);
        drv_a(0, 0, nop, 0, 0, 0);
        @(negedge clk);
        chk("a beq branch_cnt", 32'(bus_a.branch_cnt), 1);
        chk("a beq taken_cnt", 32'(bus_a.taken_cnt), 1);

        drv_a(1, 0, f_i(6'b000001, 5'b10001, 16'h0010), 32'h200, 32'hFFFF_FFFF, 0);
        push(lq_a, cyc, 32'h208, 5'd31);
        drv_a(0, 0, nop, 0, 0, 0);
        @(negedge clk);
        chk("a bgezal branch_cnt", 32'(bus_a.branch_cnt), 2);
        chk("a bgezal taken_cnt", 32'(bus_a.taken_cnt), 1);

        drv_a(1, 0, f_i(6'b010101, 5'd4, 16'h0008), 32'h300, 7, 7);
        drv_a(1, 1, f_j(6'b000011, 26'h55), 32'h304, 0, 0);
        @(negedge clk);
        chk("a annul under stall", 32'(bus_a.annul), 1);
        drv_a(1, 0, f_j(6'b000011, 26'h55), 32'h304, 0, 0);
        @(negedge clk);
        chk("a annul slot", 32'(bus_a.annul), 1);
        drv_a(0, 0, nop, 0, 0, 0);
        @(negedge clk);
        chk("a annul released", 32'(bus_a.annul), 0);
        chk("a annul no fault", 32'(bus_a.ds_fault), 0);
        chk("a bnel branch_cnt", 32'(bus_a.branch_cnt), 3);
        chk("a bnel taken_cnt", 32'(bus_a.taken_cnt), 1);

        drv_a(1, 0, f_i(6'b010100, 5'd4, 16'h0001), 32'h400, 1, 1);
        drv_a(1, 0, nop, 32'h404, 0, 0); push(rq_a, cyc + 1, 32'h408, 0);
        @(negedge clk);
        chk("a beql slot not annulled", 32'(bus_a.annul), 0);
        drv_a(0, 0, nop, 0, 0, 0);

        drv_a(1, 0, f_j(6'b000010, 26'h100), 32'h1000_0500, 0, 0);
        drv_a(1, 0, f_r(5'd5, 6'b001001), 32'h1000_0504, 32'h55, 0);
        push(rq_a, cyc + 1, 32'h1000_0400, 0);
        drv_a(0, 0, nop, 0, 0, 0);
        drv_a(0, 0, nop, 0, 0, 0);
        @(negedge clk);
        chk("a ds_fault set", 32'(bus_a.ds_fault), 1);
        chk("a j branch_cnt", 32'(bus_a.branch_cnt), 5);
        chk("a j taken_cnt", 32'(bus_a.taken_cnt), 3);

        drv_a(1, 0, f_r(5'd0, 6'b001001), 32'h600, 32'h00AB_CDE0, 0);
        push(lq_a, cyc, 32'h608, 5'd0);
        drv_a(1, 0, nop, 32'h604, 0, 0); push(rq_a, cyc + 1, 32'h00AB_CDE0, 0);
        drv_a(0, 0, nop, 0, 0, 0);
        @(negedge clk);
        chk("a ds_fault sticky", 32'(bus_a.ds_fault), 1);
        chk("a jalr branch_cnt", 32'(bus_a.branch_cnt), 6);

        // ---------------- unit B: two delay slots, 2-bit counters ----------------
        drv_b(0, 0, nop, 0, 0, 0);
        @(negedge clk);
        chk("b reset branch_cnt", 32'(bus_b.branch_cnt), 0);
        drv_b(0, 0, nop, 0, 0, 0); reset_b = 1'b1;

        drv_b(1, 0, f_i(6'b000111, 5'd0, 16'h0004), 32'h100, 0, 0);
        drv_b(0, 0, nop, 0, 0, 0);
        @(negedge clk);
        chk("b bgtz zero branch_cnt", 32'(bus_b.branch_cnt), 1);
        chk("b bgtz zero taken_cnt", 32'(bus_b.taken_cnt), 0);

        drv_b(1, 0, f_i(6'b000111, 5'd0, 16'h0004), 32'h200, 1, 0);
        drv_b(1, 0, nop, 32'h204, 0, 0);
        drv_b(0, 0, nop, 0, 0, 0); reset_b = 1'b0;
        drv_b(1, 0, nop, 32'h208, 0, 0); reset_b = 1'b1;
        repeat (3) drv_b(1, 0, nop, 32'h20C, 0, 0);
        @(negedge clk);
        chk("b post-reset branch_cnt", 32'(bus_b.branch_cnt), 0);
        chk("b post-reset taken_cnt", 32'(bus_b.taken_cnt), 0);
        chk("b post-reset target", bus_b.redirect_target, 0);
        chk("b post-reset ds_fault", 32'(bus_b.ds_fault), 0);

        drv_b(1, 0, f_i(6'b010100, 5'd4, 16'h0004), 32'h280, 2, 2);
        drv_b(0, 0, nop, 0, 0, 0);
        @(negedge clk);
        chk("b likely undecoded", 32'(bus_b.branch_cnt), 0);

        drv_b(1, 0, f_i(6'b000001, 5'b10000, 16'hFFFF), 32'h300, 32'hFFFF_FFFF, 0);
        push(lq_b, cyc, 32'h30C, 5'd31);
        drv_b(1, 0, nop, 32'h304, 0, 0);
        drv_b(1, 1, nop, 32'h308, 0, 0);
        drv_b(1, 0, nop, 32'h308, 0, 0); push(rq_b, cyc + 1, 32'h300, 0);
        drv_b(0, 0, nop, 0, 0, 0);
        @(negedge clk);
        chk("b bltzal taken_cnt", 32'(bus_b.taken_cnt), 1);

        for (int i = 0; i < 5; i++) begin
            drv_b(1, 0, f_j(6'b000010, 26'(32'h40 + i)), 32'h800, 0, 0);
            drv_b(1, 0, nop, 32'h804, 0, 0);
            drv_b(1, 0, nop, 32'h808, 0, 0); push(rq_b, cyc + 1, 32'h100 + 4 * i, 0);
            drv_b(0, 0, nop, 0, 0, 0);
        end
        @(negedge clk);
        chk("b taken_cnt saturated", 32'(bus_b.taken_cnt), 3);
        chk("b branch_cnt saturated", 32'(bus_b.branch_cnt), 3);

        drv_b(1, 0, f_j(6'b000010, 26'h80), 32'h900, 0, 0); bus_b.clr_cnt = 1'b1;
        drv_b(1, 0, nop, 32'h904, 0, 0); bus_b.clr_cnt = 1'b0;
        drv_b(1, 0, nop, 32'h908, 0, 0); push(rq_b, cyc + 1, 32'h200, 0);
        drv_b(0, 0, nop, 0, 0, 0);
        @(negedge clk);
        chk("b clr taken_cnt", 32'(bus_b.taken_cnt), 0);
        chk("b clr branch_cnt", 32'(bus_b.branch_cnt), 0);

        repeat (3) drv_b(0, 0, nop, 0, 0, 0);
        @(negedge clk);
        chk("a redirects outstanding", rq_a.size(), 0);
        chk("a links outstanding", lq_a.size(), 0);
        chk("b redirects outstanding", rq_b.size(), 0);
        chk("b links outstanding", lq_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the EXEC-stage jump/branch decision logic.
- Evaluates all MIPS-I control-transfer instructions from register operands, computes the target, and generates link writes.
- Sequences the redirect after a configurable number of delay slots, optionally annulling delay slots of not-taken branch-likely instructions.
- Keeps saturating branch statistics. Sits between the EXEC stage and the PC/fetch logic.

Parameters:
- ADDR_W, 32, PC/target width (24..32); addresses are truncated to ADDR_W.
- DELAY_SLOTS, 1, number of architectural delay slots (0..3).
- LIKELY_EN, 0, 1 = decode BEQL/BNEL/BLEZL/BGTZL (opcodes 010100..010111).
- CNT_W, 16, statistics counter width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- instr_valid  in  1  an instruction is in EXEC this cycle.
- stall  in  1  pipeline hold; instruction is not accepted while high.
- instr_word  in  32  instruction in EXEC.
- pc  in  ADDR_W  address of the instruction in EXEC.
- rs_val  in  32  rs operand.
- rt_val  in  32  rt operand.
- clr_cnt  in  1  synchronous clear of the statistics counters.
- redirect  out  1  one-cycle pulse: load redirect_target into PC.
- redirect_target  out  ADDR_W  registered target, valid while redirect=1.
- annul  out  1  high while delay-slot instructions are being squashed.
- link_we  out  1  link register write enable (combinational).
- link_reg  out  5  rd for JALR, 31 otherwise.
- link_value  out  ADDR_W  pc + 4*(DELAY_SLOTS+1).
- ds_fault  out  1  sticky: control instruction found in a delay slot.
- branch_cnt  out  CNT_W  evaluated control instructions (saturating).
- taken_cnt  out  CNT_W  taken control instructions (saturating).

Behaviour:
- Accept = instr_valid & !stall. Nothing changes state without an accept, except reset and clr_cnt.
- Decode:
  - J (000010) and JAL (000011): target = {(pc+4)[ADDR_W-1:28], index, 2'b00}; always taken.
  - JR and JALR (op 0, funct 001000/001001): target = rs_val[ADDR_W-1:0]; always taken.
  - BEQ 000100, BNE 000101, BLEZ 000110, BGTZ 000111 (rs>0 signed, strictly non-zero).
  - REGIMM 000001, rt field: BLTZ 00000, BGEZ 00001, BLTZAL 10000, BGEZAL 10001.
  - All branch comparisons are signed 32-bit. Branch target = pc + 4 + (sext(imm16)<<2), modulo 2^ADDR_W.
- Link:
  - link_we = accept & IDLE & (JAL | JALR | BLTZAL | BGEZAL).
  - Link is unconditional, i.e. also when the branch is not taken.
  - JALR with rd=0 still asserts link_we; the register file ignores r0.
- States:
  - IDLE
  - PEND(n): taken transfer waiting for n remaining delay slots.
  - ANNUL(n): not-taken likely branch; squash n slots.
  - REDIR: redirect cycle.
- Transitions from IDLE on an accepted control instruction:
  - Taken: capture target. If DELAY_SLOTS=0, go to REDIR; else go to PEND(DELAY_SLOTS).
  - Not-taken likely with LIKELY_EN=1 and DELAY_SLOTS>0: go to ANNUL(DELAY_SLOTS).
  - Otherwise: stay in IDLE.
- PEND(n):
  - Each accept decrements n; the accept at n=1 goes to REDIR.
  - An accepted control instruction counts as a slot but is not evaluated: no link, no counters, ds_fault<=1.
- ANNUL(n): annul=1. Each accept decrements n; the accept at n=1 goes to IDLE. Squashed instructions never fault, link or count.
- REDIR:
  - redirect=1 for exactly this cycle, independent of stall. Next state is IDLE.
  - An instr_valid in REDIR is wrong-path: ignored, no link.
- Timing: redirect rises one cycle after the last delay slot is accepted. With DELAY_SLOTS=0 it rises one cycle after the branch is accepted.
- Counters: branch_cnt++ per evaluated control instruction; taken_cnt++ when taken. Both saturate at all-ones. clr_cnt has priority over increment.
- Reset (reset_n=0 at posedge): state IDLE, redirect=0, redirect_target=0, annul=0, ds_fault=0, counters=0. A pending redirect is discarded. link_we=0 while reset_n=0.
- Non-control instructions are not counted.

Test Plan:
- DELAY_SLOTS=1: BEQ at pc=0x100, rs=rt=5, imm=0x0003, then one accept at 0x104 -> redirect high one cycle after that accept, target 0x110; branch_cnt=1, taken_cnt=1.
- BGEZAL at pc=0x200, rs=0xFFFFFFFF -> not taken, link_we=1, link_reg=31, link_value=0x208, no redirect.
- LIKELY_EN=1, DELAY_SLOTS=1: BNEL with rs=rt -> annul=1 for the next accept only, then IDLE, no redirect. A stall during ANNUL holds annul high.
- Taken J, then JR in the delay slot -> JR not evaluated, ds_fault=1 (sticky), redirect to J target only; branch_cnt=1.
- DELAY_SLOTS=2, taken BGTZ, reset_n=0 after the first slot -> no redirect afterwards; all outputs zero. BGTZ with rs=0 -> not taken.
- CNT_W=2: five taken jumps -> taken_cnt saturates at 3. clr_cnt together with an accepted jump -> counter 0.
